axis_rr_arbiter: RTL and testbench

//   Shares one downstream AXI-Stream consumer (the stream FIFO) between NUM_SRC
//   AXI-Stream sources (e.g. LFSR generators). Round-robin grant, held for a packet
//   (until tlast) or MAX_BURST beats, whichever comes first. Registered output stage;

---
 rtl/axis_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream arbiter: NUM_SRC sources share one registered master port.
// A grant lasts one packet or MAX_BURST beats, and the source index is forwarded on m_axis_tid.
module axis_rr_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8,
  localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [IDW-1:0]                m_axis_tid,
  input  logic                          m_axis_tready,
  output logic                          grant_active,
  output logic [IDW-1:0]                grant_idx
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] LAST_SRC  = IDW'(NUM_SRC - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                  state_r, state_nxt_s;
  logic [IDW-1:0]          rr_ptr_r, grant_idx_r, pick_idx_s, rr_nxt_s;
  logic [CW-1:0]           beat_cnt_r;
  logic                    pick_found_s, out_ready_s, accept_s, release_s;
  logic                    sel_last_s, burst_end_s;
  logic [DATA_WIDTH-1:0]   sel_data_s, m_tdata_r;
  logic                    m_tvalid_r, m_tlast_r;
  logic [IDW-1:0]          m_tid_r;
  logic [NUM_SRC-1:0]      s_tready_s;

  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] ptr, input int k);
    int sum;
    sum = int'(ptr) + k;
    return (sum >= NUM_SRC) ? IDW'(sum - NUM_SRC) : IDW'(sum);
  endfunction

  assign out_ready_s = !m_tvalid_r || m_axis_tready;
  assign sel_data_s  = s_axis_tdata[grant_idx_r*DATA_WIDTH +: DATA_WIDTH];
  assign sel_last_s  = s_axis_tlast[grant_idx_r];
  assign burst_end_s = (beat_cnt_r == LAST_BEAT);
  assign accept_s    = (state_r == GRANT) && s_axis_tvalid[grant_idx_r] && out_ready_s;
  assign release_s   = accept_s && (sel_last_s || burst_end_s);
  assign rr_nxt_s    = (grant_idx_r == LAST_SRC) ? {IDW{1'b0}} : grant_idx_r + IDW'(1'b1);

  // Round-robin search: first valid source starting at rr_ptr
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = {IDW{1'b0}};
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!pick_found_s && s_axis_tvalid[rr_index(rr_ptr_r, k)]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = rr_index(rr_ptr_r, k);
      end else begin
        pick_idx_s   = pick_idx_s;
      end
    end
  end

  // FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (pick_found_s) state_nxt_s = GRANT; else state_nxt_s = IDLE;
      GRANT:   if (release_s)    state_nxt_s = IDLE;  else state_nxt_s = GRANT;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: ready only to the granted source, never looking at its tvalid
  always_comb begin
    s_tready_s = {NUM_SRC{1'b0}};
    if (state_r == GRANT) begin
      s_tready_s[grant_idx_r] = out_ready_s;
    end else begin
      s_tready_s = {NUM_SRC{1'b0}};
    end
  end

  // FSM state, grant bookkeeping and round-robin pointer
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {IDW{1'b0}};
      grant_idx_r <= {IDW{1'b0}};
      beat_cnt_r  <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            grant_idx_r <= pick_idx_s;
            beat_cnt_r  <= {CW{1'b0}};
          end
        end
        GRANT: begin
          if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + CW'(1'b1);
            if (release_s) begin
              rr_ptr_r <= rr_nxt_s;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output register: load on accept, hold under backpressure, else drain
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_tdata_r  <= {DATA_WIDTH{1'b0}};
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
      m_tid_r    <= {IDW{1'b0}};
    end else if (accept_s) begin
      m_tdata_r  <= sel_data_s;
      m_tvalid_r <= 1'b1;
      m_tlast_r  <= sel_last_s | burst_end_s;
      m_tid_r    <= grant_idx_r;
    end else if (out_ready_s) begin
      m_tvalid_r <= 1'b0;
    end
  end

  assign s_axis_tready = s_tready_s;
  assign m_axis_tdata  = m_tdata_r;
  assign m_axis_tvalid = m_tvalid_r;
  assign m_axis_tlast  = m_tlast_r;
  assign m_axis_tid    = m_tid_r;
  assign grant_active  = (state_r == GRANT);
  assign grant_idx     = grant_idx_r;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: source queues feed the DUT, accepted beats are
// pushed as expectations and popped when the master port transfers them.
module tb_axis_rr_arbiter;
  localparam int NS  = 4;
  localparam int DW  = 32;
  localparam int MB  = 8;
  localparam int IDW = 2;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS-1:0]     s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid, m_tlast, m_tready;
  logic [IDW-1:0]    m_tid, grant_idx;
  logic              grant_active;

  always #5 aclk = ~aclk;

  axis_rr_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid), .m_axis_tready(m_tready),
    .grant_active(grant_active), .grant_idx(grant_idx)
  );

  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [DW-1:0] data; logic [IDW-1:0] tid; logic last; int cyc; } exp_t;

  beat_t src_q [NS][$];
  exp_t  sb_q[$];
  int    acc_src[$];
  int    acc_cyc[$];
  int    total = 0, bad = 0, cyc = 0, mdl_cnt = 0;
  bit    lat_chk = 1'b0, ga_chk = 1'b0, ga_pending = 1'b0, prev_stall = 1'b0;
  logic [DW-1:0]  cap_data;
  logic           cap_last;
  logic [IDW-1:0] cap_tid;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0) begin
        s_tvalid[i]          = 1'b1;
        s_tdata[i*DW +: DW]  = src_q[i][0].data;
        s_tlast[i]           = src_q[i][0].last;
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tdata[i*DW +: DW]  = '0;
        s_tlast[i]           = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive, evaluate handshakes mid-cycle, advance past the edge
  task automatic step();
    beat_t b;
    exp_t  e;
    drive();
    #3;
    if (aresetn) begin
      if (ga_pending) begin
        check_val("grant_fall", grant_active, 1'b0);
        ga_pending = 1'b0;
      end
      check_val("s_tready_onehot", $countones(s_tready) <= 1, 1'b1);
      if (prev_stall) begin
        check_val("stall_data", m_tdata, cap_data);
        check_val("stall_tid", m_tid, cap_tid);
        check_val("stall_last", m_tlast, cap_last);
      end
      prev_stall = m_tvalid && !m_tready;
      cap_data = m_tdata; cap_tid = m_tid; cap_last = m_tlast;
      if (prev_stall) check_val("stall_s_tready", s_tready, '0);
      if (m_tvalid && m_tready) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_beat", m_tdata, 64'hdead);
        end else begin
          e = sb_q.pop_front();
          check_val("m_tdata", m_tdata, e.data);
          check_val("m_tid", m_tid, e.tid);
          check_val("m_tlast", m_tlast, e.last);
          if (lat_chk) check_val("latency", cyc - e.cyc, 1);
        end
      end
      for (int i = 0; i < NS; i++) begin
        if (s_tvalid[i] && s_tready[i]) begin
          b = src_q[i].pop_front();
          mdl_cnt++;
          e.data = b.data; e.tid = IDW'(i); e.cyc = cyc;
          e.last = b.last || (mdl_cnt == MB);
          if (e.last) mdl_cnt = 0;
          if (ga_chk && b.last) ga_pending = 1'b1;
          sb_q.push_back(e);
          acc_src.push_back(i);
          acc_cyc.push_back(cyc);
        end
      end
    end
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  // Reset drops any in-flight data; sources restart empty as well
  task automatic do_reset();
    aresetn = 1'b0;
    step();
    step();
    check_val("rst_m_tvalid", m_tvalid, 1'b0);
    check_val("rst_m_tdata", m_tdata, '0);
    check_val("rst_m_tlast", m_tlast, 1'b0);
    check_val("rst_m_tid", m_tid, '0);
    check_val("rst_s_tready", s_tready, '0);
    check_val("rst_grant_active", grant_active, 1'b0);
    check_val("rst_grant_idx", grant_idx, '0);
    for (int i = 0; i < NS; i++) src_q[i].delete();
    sb_q.delete();
    acc_src.delete();
    acc_cyc.delete();
    mdl_cnt = 0;
    prev_stall = 1'b0;
    ga_pending = 1'b0;
    aresetn = 1'b1;
  endtask

  function automatic bit pending();
    bit p;
    p = (sb_q.size() != 0) || m_tvalid;
    for (int i = 0; i < NS; i++) p = p || (src_q[i].size() != 0);
    return p;
  endfunction

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    check_val("drained", pending(), 1'b0);
  endtask

  task automatic push_pkt(input int src, input int base, input int len, input bit with_last);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = DW'(base + k);
      b.last = with_last && (k == len - 1);
      src_q[src].push_back(b);
    end
  endtask

  initial begin
    int exp_seq[$];
    aresetn  = 1'b0;
    m_tready = 1'b1;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0;

    // 1: single 3-beat packet from source 0
    do_reset();
    lat_chk = 1'b1; ga_chk = 1'b1;
    push_pkt(0, 'hA0, 3, 1'b1);
    run_idle(40);
    ga_chk = 1'b0;
    check_val("t1_beats", acc_src.size(), 3);
    check_val("t1_grant_fall_seen", ga_pending, 1'b0);

    // 2: all sources continuously valid with 1-beat packets
    do_reset();
    for (int i = 0; i < NS; i++) begin
      push_pkt(i, 'h200 + i*16, 1, 1'b1);
      push_pkt(i, 'h208 + i*16, 1, 1'b1);
    end
    run_idle(100);
    check_val("t2_count", acc_src.size(), 8);
    for (int k = 0; k < 6; k++) check_val("t2_order", acc_src[k], k % NS);
    for (int k = 1; k < 6; k++) check_val("t2_gap", acc_cyc[k] - acc_cyc[k-1], 2);

    // 3: long packet on source 1 is cut into MAX_BURST grants, source 2 interleaves
    do_reset();
    push_pkt(1, 'h1000, 20, 1'b1);
    push_pkt(2, 'h2000, 3, 1'b1);
    run_idle(200);
    exp_seq.delete();
    for (int k = 0; k < 8; k++) exp_seq.push_back(1);
    for (int k = 0; k < 3; k++) exp_seq.push_back(2);
    for (int k = 0; k < 12; k++) exp_seq.push_back(1);
    check_val("t3_count", acc_src.size(), exp_seq.size());
    for (int k = 0; k < exp_seq.size(); k++) check_val("t3_order", acc_src[k], exp_seq[k]);

    // 4: downstream stall of 5 cycles mid-packet
    do_reset();
    lat_chk = 1'b0;
    push_pkt(0, 'h4000, 6, 1'b1);
    for (int k = 0; k < 4; k++) step();
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check_val("t4_stalled_valid", m_tvalid, 1'b1);
    m_tready = 1'b1;
    run_idle(60);
    check_val("t4_count", acc_src.size(), 6);

    // 5: reset in the middle of a source-2 packet
    do_reset();
    lat_chk = 1'b1;
    push_pkt(2, 'h5000, 10, 1'b1);
    for (int k = 0; k < 5; k++) step();
    check_val("t5_midpkt", grant_active, 1'b1);
    do_reset();
    push_pkt(0, 'h5100, 2, 1'b1);
    push_pkt(2, 'h5200, 2, 1'b1);
    run_idle(60);
    check_val("t5_first_src", acc_src[0], 0);
    check_val("t5_second_src", acc_src[2], 2);

    // 6: pointer wraps from source 3 back to source 0
    do_reset();
    push_pkt(3, 'h6300, 1, 1'b1);
    run_idle(30);
    check_val("t6_src3", acc_src[0], 3);
    acc_src.delete();
    push_pkt(0, 'h6000, 1, 1'b1);
    push_pkt(3, 'h6301, 1, 1'b1);
    run_idle(30);
    check_val("t6_wrap_first", acc_src[0], 0);
    check_val("t6_wrap_second", acc_src[1], 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
